regfile_checker: RTL and testbench

- Synthesizable self-check block for processor-level simulation and FPGA bring-up.
- Snoops the register-file writeback port, keeps a shadow register file, and after a programmable run length compares selected registers against a loaded expected-value table.
- Replaces fixed-time, hard-coded register checks with a parametrised, cycle-accurate pass/fail engine.
- Instantiated next to arm_processor; connected only through ports, with no hierarchical references.

---
 rtl/regfile_checker_pkg.sv | 28 ++
 rtl/regfile_checker_shadow_regfile.sv | 31 +++
 rtl/regfile_checker.sv | 132 +++++++++++++
 tb/tb_regfile_checker.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/regfile_checker_pkg.sv
// Shared types and width helpers for the register-file self-check engine.
// The check-entry struct fixes the table field widths; the top's defaults match them.
package regfile_checker_pkg;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_CHECK, S_DONE} state_t;

  localparam int ENTRY_REG_AW = 4;
  localparam int ENTRY_DATA_W = 32;

  typedef struct packed {
    logic                    valid;
    logic [ENTRY_REG_AW-1:0] regnum;
    logic [ENTRY_DATA_W-1:0] value;
  } check_entry_t;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int cnt_w(input int n);
    return $clog2(n + 1);
  endfunction

  localparam int DEF_NUM_CHECKS = 4;
  localparam int CHK_IDX_W      = idx_w(DEF_NUM_CHECKS);
  localparam int FAIL_CNT_W     = cnt_w(DEF_NUM_CHECKS);

endpackage

// File: rtl/regfile_checker_shadow_regfile.sv
// Shadow copy of the architectural register file: sync write, comb read, sync clear-all.
// Out-of-range addresses are dropped on write and read back as zero.
module shadow_regfile #(
  parameter int NUM_REGS = 16,
  parameter int DATA_W   = 32,
  parameter int REG_AW   = 4
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              we,
  input  logic [REG_AW-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [REG_AW-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  localparam logic [REG_AW:0] NREGS = (REG_AW + 1)'(NUM_REGS);

  logic [DATA_W-1:0] mem [NUM_REGS];

  always_ff @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < NUM_REGS; i++) mem[i] <= '0;
    end else if (we && ({1'b0, waddr} < NREGS)) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = ({1'b0, raddr} < NREGS) ? mem[raddr] : '0;

endmodule

// File: rtl/regfile_checker.sv
// Snoops register writeback for run_len cycles, then compares the shadow file against a table.
// Result appears NUM_CHECKS cycles after the run ends (max(run_len,1)+NUM_CHECKS after start).
module regfile_checker
  import regfile_checker_pkg::*;
#(
  parameter int NUM_REGS   = 16,
  parameter int DATA_W     = ENTRY_DATA_W,
  parameter int REG_AW     = ENTRY_REG_AW,
  parameter int NUM_CHECKS = 4,
  parameter int CNT_W      = 16
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            cfg_we,
  input  logic [idx_w(NUM_CHECKS)-1:0]    cfg_idx,
  input  logic                            cfg_valid,
  input  logic [REG_AW-1:0]               cfg_reg,
  input  logic [DATA_W-1:0]               cfg_value,
  input  logic                            start,
  input  logic [CNT_W-1:0]                run_len,
  input  logic                            wb_en,
  input  logic [REG_AW-1:0]               wb_addr,
  input  logic [DATA_W-1:0]               wb_data,
  output logic                            busy,
  output logic                            done,
  output logic                            pass,
  output logic [cnt_w(NUM_CHECKS)-1:0]    fail_count,
  output logic [idx_w(NUM_CHECKS)-1:0]    first_fail_idx,
  output logic [DATA_W-1:0]               first_fail_actual,
  output logic [CNT_W-1:0]                cycle_count
);

  localparam int              IW       = idx_w(NUM_CHECKS);
  localparam logic [IW:0]     NCHK     = (IW + 1)'(NUM_CHECKS);
  localparam logic [IW-1:0]   LAST_IDX = IW'(NUM_CHECKS - 1);
  localparam logic [REG_AW:0] NREGS    = (REG_AW + 1)'(NUM_REGS);

  state_t            state, state_nxt;
  check_entry_t      chk_tab [NUM_CHECKS];
  check_entry_t      entry;
  logic [CNT_W-1:0]  run_len_q;
  logic [IW-1:0]     chk_idx;
  logic [DATA_W-1:0] rd_data;
  logic [DATA_W-1:0] actual;
  logic              idle_or_done, accept_start, last_run, reg_ok, entry_fail;

  assign idle_or_done = (state == S_IDLE) || (state == S_DONE);
  assign accept_start = idle_or_done && start;
  // A zero length still spends one cycle in RUN.
  assign last_run     = (run_len_q == '0) || (cycle_count == run_len_q - 1'b1);

  assign entry      = chk_tab[chk_idx];
  assign reg_ok     = ({1'b0, entry.regnum} < NREGS);
  assign actual     = reg_ok ? rd_data : '0;
  assign entry_fail = (state == S_CHECK) && entry.valid &&
                      (!reg_ok || (actual != entry.value));

  shadow_regfile #(
    .NUM_REGS (NUM_REGS),
    .DATA_W   (DATA_W),
    .REG_AW   (REG_AW)
  ) u_shadow (
    .clk   (clk),
    .clr   (reset || accept_start),
    .we    ((state == S_RUN) && wb_en),
    .waddr (wb_addr),
    .wdata (wb_data),
    .raddr (entry.regnum),
    .rdata (rd_data)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE, S_DONE: if (start) state_nxt = S_RUN;
      S_RUN:          if (last_run) state_nxt = S_CHECK;
      S_CHECK:        if (chk_idx == LAST_IDX) state_nxt = S_DONE;
      default:        state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cycle_count       <= '0;
      run_len_q         <= '0;
      chk_idx           <= '0;
      fail_count        <= '0;
      first_fail_idx    <= '0;
      first_fail_actual <= '0;
      for (int i = 0; i < NUM_CHECKS; i++) chk_tab[i] <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (cfg_we && ({1'b0, cfg_idx} < NCHK))
            chk_tab[cfg_idx] <= '{valid: cfg_valid, regnum: cfg_reg, value: cfg_value};
          if (start) begin
            cycle_count       <= '0;
            run_len_q         <= run_len;
            chk_idx           <= '0;
            fail_count        <= '0;
            first_fail_idx    <= '0;
            first_fail_actual <= '0;
          end
        end
        S_RUN: begin
          if (cycle_count != '1) cycle_count <= cycle_count + 1'b1;
        end
        S_CHECK: begin
          chk_idx <= (chk_idx == LAST_IDX) ? '0 : chk_idx + 1'b1;
          if (entry_fail) begin
            fail_count <= fail_count + 1'b1;
            if (fail_count == '0) begin
              first_fail_idx    <= chk_idx;
              first_fail_actual <= actual;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign busy = (state == S_RUN) || (state == S_CHECK);
  assign done = (state == S_DONE);
  assign pass = done && (fail_count == '0);

endmodule

// File: tb/tb_regfile_checker.sv
// Bench for regfile_checker with NUM_REGS=12: vector table of runs plus hand-written corner sequences.
module tb_regfile_checker;

  localparam int NR = 12;
  localparam int DW = 32;
  localparam int AW = 4;
  localparam int NC = 4;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          cfg_we, cfg_valid, start, wb_en;
  logic [1:0]    cfg_idx;
  logic [AW-1:0] cfg_reg, wb_addr;
  logic [DW-1:0] cfg_value, wb_data;
  logic [CW-1:0] run_len;
  logic          busy, done, pass;
  logic [2:0]    fail_count;
  logic [1:0]    first_fail_idx;
  logic [DW-1:0] first_fail_actual;
  logic [CW-1:0] cycle_count;

  regfile_checker #(
    .NUM_REGS(NR), .DATA_W(DW), .REG_AW(AW), .NUM_CHECKS(NC), .CNT_W(CW)
  ) dut (
    .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_valid(cfg_valid),
    .cfg_reg(cfg_reg), .cfg_value(cfg_value), .start(start), .run_len(run_len),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data), .busy(busy), .done(done),
    .pass(pass), .fail_count(fail_count), .first_fail_idx(first_fail_idx),
    .first_fail_actual(first_fail_actual), .cycle_count(cycle_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [3:0]  a1; logic [31:0] d1;
    logic [3:0]  a2; logic [31:0] d2;
    logic        e3v; logic [3:0] e3r; logic [31:0] e3d;
    logic [15:0] len;
    logic        pass; logic [2:0] fc; logic [1:0] idx; logic [31:0] act;
  } vec_t;

  typedef struct {
    logic        pass; logic [2:0] fc; logic [1:0] idx; logic [31:0] act;
    logic [15:0] cc; int lat;
  } exp_t;

  exp_t exp_q[$];
  vec_t vecs[6];
  int   n_cmp = 0;
  int   n_fail = 0;
  int   start_cyc = 0;

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h want 0x%0h", nm, got, want);
    end
  endtask

  task automatic cfg(input logic [1:0] idx, input logic v, input logic [3:0] r, input logic [31:0] d);
    cfg_we = 1'b1; cfg_idx = idx; cfg_valid = v; cfg_reg = r; cfg_value = d;
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic load_table();
    cfg(2'd0, 1'b1, 4'd0, 32'd0);
    cfg(2'd1, 1'b1, 4'd1, 32'd4);
    cfg(2'd2, 1'b1, 4'd2, 32'd2);
    cfg(2'd3, 1'b0, 4'd0, 32'd0);
  endtask

  task automatic pulse_start(input logic [15:0] len);
    start = 1'b1; run_len = len;
    tick();
    start = 1'b0; cfg_we = 1'b0; run_len = 16'hBEEF;
    start_cyc = cyc;
  endtask

  task automatic wb(input logic en, input logic [3:0] a, input logic [31:0] d);
    wb_en = en; wb_addr = a; wb_data = d;
  endtask

  task automatic push(input logic p, input logic [2:0] fc, input logic [1:0] idx,
                      input logic [31:0] act, input logic [15:0] len);
    exp_t e;
    e.pass = p; e.fc = fc; e.idx = idx; e.act = act;
    e.cc  = (len == 0) ? 16'd1 : len;
    e.lat = ((len == 0) ? 1 : int'(len)) + NC;
    exp_q.push_back(e);
  endtask

  task automatic wait_done(input string nm);
    exp_t e;
    int   k;
    k = 0;
    while (!done && k < 300) begin
      tick();
      k++;
    end
    chk({nm, "_done"}, {31'd0, done}, 32'd1);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk({nm, "_pass"}, {31'd0, pass}, {31'd0, e.pass});
      chk({nm, "_fail_count"}, {29'd0, fail_count}, {29'd0, e.fc});
      chk({nm, "_first_idx"}, {30'd0, first_fail_idx}, {30'd0, e.idx});
      chk({nm, "_first_actual"}, first_fail_actual, e.act);
      chk({nm, "_cycle_count"}, {16'd0, cycle_count}, {16'd0, e.cc});
      chk({nm, "_latency"}, cyc - start_cyc, e.lat);
      repeat (3) tick();
      chk({nm, "_hold"}, {28'd0, done, fail_count}, {28'd0, 1'b1, e.fc});
    end
  endtask

  task automatic run_vec(input string nm, input vec_t v);
    cfg_we = 1'b1; cfg_idx = 2'd3; cfg_valid = v.e3v; cfg_reg = v.e3r; cfg_value = v.e3d;
    pulse_start(v.len);
    push(v.pass, v.fc, v.idx, v.act, v.len);
    wb(1'b1, v.a1, v.d1); tick();
    wb(1'b1, v.a2, v.d2); tick();
    wb(1'b0, 4'd0, 32'd0);
    wait_done(nm);
  endtask

  initial begin
    // Base table: e0 R0==0, e1 R1==4, e2 R2==2; entry 3 is reloaded with each start.
    vecs[0] = '{4'd1, 32'd4, 4'd2, 32'd2, 1'b0, 4'd0,  32'd0, 16'd20, 1'b1, 3'd0, 2'd0, 32'd0};
    vecs[1] = '{4'd1, 32'd4, 4'd2, 32'd3, 1'b0, 4'd0,  32'd0, 16'd20, 1'b0, 3'd1, 2'd2, 32'd3};
    vecs[2] = '{4'd0, 32'd5, 4'd1, 32'd4, 1'b0, 4'd0,  32'd0, 16'd8,  1'b0, 3'd2, 2'd0, 32'd5};
    vecs[3] = '{4'd15, 32'd4, 4'd2, 32'd2, 1'b1, 4'd3, 32'd5, 16'd5,  1'b0, 3'd2, 2'd1, 32'd0};
    vecs[4] = '{4'd1, 32'd7, 4'd1, 32'd4, 1'b1, 4'd13, 32'd0, 16'd3,  1'b0, 3'd2, 2'd2, 32'd0};
    vecs[5] = '{4'd1, 32'd4, 4'd2, 32'd2, 1'b1, 4'd11, 32'd0, 16'd2,  1'b1, 3'd0, 2'd0, 32'd0};

    reset = 1'b1; cfg_we = 1'b0; cfg_idx = '0; cfg_valid = 1'b0; cfg_reg = '0; cfg_value = '0;
    start = 1'b0; run_len = '0; wb_en = 1'b0; wb_addr = '0; wb_data = '0;
    repeat (2) tick();
    reset = 1'b0;
    tick();
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_pass", {31'd0, pass}, 32'd0);
    chk("rst_fail_count", {29'd0, fail_count}, 32'd0);
    chk("rst_cycle_count", {16'd0, cycle_count}, 32'd0);
    chk("rst_first_idx", {30'd0, first_fail_idx}, 32'd0);
    chk("rst_first_actual", first_fail_actual, 32'd0);

    load_table();
    for (int i = 0; i < 6; i++) run_vec($sformatf("vec%0d", i), vecs[i]);

    // Final-RUN-cycle write is captured; a write in the first CHECK cycle is not.
    load_table();
    pulse_start(16'd4);
    push(1'b1, 3'd0, 2'd0, 32'd0, 16'd4);
    wb(1'b1, 4'd2, 32'd2); tick();
    wb(1'b0, 4'd0, 32'd0); tick();
    tick();
    wb(1'b1, 4'd1, 32'd4); tick();
    chk("last_cyc_in_check", {31'd0, busy}, 32'd1);
    chk("last_cyc_count", {16'd0, cycle_count}, 32'd4);
    wb(1'b1, 4'd1, 32'd9); tick();
    wb(1'b0, 4'd0, 32'd0);
    wait_done("last_cyc");

    // Zero run length: one RUN cycle whose write still lands.
    pulse_start(16'd0);
    push(1'b0, 3'd3, 2'd0, 32'd7, 16'd0);
    wb(1'b1, 4'd0, 32'd7); tick();
    wb(1'b0, 4'd0, 32'd0);
    wait_done("len0");

    // start / cfg_we / out-of-range writeback during RUN must all be ignored.
    load_table();
    pulse_start(16'd10);
    push(1'b1, 3'd0, 2'd0, 32'd0, 16'd10);
    wb(1'b1, 4'd1, 32'd4); tick();
    wb(1'b1, 4'd2, 32'd2); tick();
    wb(1'b1, 4'd15, 32'hDEAD); tick();
    wb(1'b0, 4'd0, 32'd0);
    start = 1'b1; run_len = 16'd1;
    cfg_we = 1'b1; cfg_idx = 2'd1; cfg_valid = 1'b1; cfg_reg = 4'd1; cfg_value = 32'd99;
    tick();
    start = 1'b0; cfg_we = 1'b0;
    wait_done("run_ignore");

    // Reset in the middle of CHECK discards everything, including the table.
    load_table();
    pulse_start(16'd2);
    repeat (3) tick();
    chk("mid_check_busy", {31'd0, busy}, 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_done", {31'd0, done}, 32'd0);
    chk("abort_fail_count", {29'd0, fail_count}, 32'd0);
    chk("abort_cycle_count", {16'd0, cycle_count}, 32'd0);
    run_vec("empty_tab", '{4'd1, 32'd9, 4'd2, 32'd9, 1'b0, 4'd0, 32'd0, 16'd2,
                           1'b1, 3'd0, 2'd0, 32'd0});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
